// File: rtl/memory_arbiter.sv
// Two-manager, one-subordinate memory arbiter with a response watchdog.
// Define ARBITER_ROUND_ROBIN_EN for round-robin arbitration; otherwise m0 has fixed priority.
module memory_arbiter #(
    parameter int unsigned WATCHDOG_CYCLES = 32'd255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] m0_rw_address,
    input  logic [31:0] m1_rw_address,
    input  logic [31:0] m0_write_data,
    input  logic [31:0] m1_write_data,
    input  logic [3:0]  m0_write_strobe,
    input  logic [3:0]  m1_write_strobe,
    input  logic        m0_read_request,
    input  logic        m1_read_request,
    input  logic        m0_write_request,
    input  logic        m1_write_request,
    output logic [31:0] m0_read_data,
    output logic [31:0] m1_read_data,
    output logic        m0_read_response,
    output logic        m1_read_response,
    output logic        m0_write_response,
    output logic        m1_write_response,
    output logic [31:0] s_rw_address,
    output logic [31:0] s_write_data,
    output logic [3:0]  s_write_strobe,
    output logic        s_read_request,
    output logic        s_write_request,
    input  logic [31:0] s_read_data,
    input  logic        s_read_response,
    input  logic        s_write_response
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

    localparam int unsigned WD_W = (WATCHDOG_CYCLES < 32'd2) ? 32'd1 : $clog2(WATCHDOG_CYCLES + 32'd1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WATCHDOG_CYCLES);
    localparam logic WD_EN = (WATCHDOG_CYCLES != 32'd0);

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              is_write_q, is_write_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        strb_q, strb_d;
    logic              rd_req_q, rd_req_d;
    logic              wr_req_q, wr_req_d;
`ifdef ARBITER_ROUND_ROBIN_EN
    logic              last_grant_q, last_grant_d;
`endif

    logic              m0_req_s, m1_req_s;
    logic              win_s;
    logic              win_write_s;
    logic              rd_done_s, wr_done_s;
    logic              rd_cpl_s, wr_cpl_s;

    // Request detection and winner selection for the next capture.
    always_comb begin
        m0_req_s = m0_read_request | m0_write_request;
        m1_req_s = m1_read_request | m1_write_request;
        win_s    = 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
        if (m0_req_s && m1_req_s) begin
            win_s = ~last_grant_q;
        end else if (m1_req_s) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
`else
        if (m0_req_s) begin
            win_s = 1'b0;
        end else if (m1_req_s) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
`endif
        // A combined read+write request is served as a write only.
        win_write_s = win_s ? m1_write_request : m0_write_request;
    end

    // Completion detection: only the response matching the transaction type counts.
    always_comb begin
        rd_done_s = (state_q == BUSY) && !is_write_q && s_read_response;
        wr_done_s = (state_q == BUSY) && is_write_q && s_write_response;
        rd_cpl_s  = !is_write_q && (rd_done_s || (state_q == TIMEOUT));
        wr_cpl_s  = is_write_q && (wr_done_s || (state_q == TIMEOUT));
    end

    // Next-state, capture and watchdog logic.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        is_write_d = is_write_q;
        wd_cnt_d   = wd_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        rd_req_d   = 1'b0;
        wr_req_d   = 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (m0_req_s || m1_req_s) begin
                    grant_d    = win_s;
                    is_write_d = win_write_s;
                    addr_d     = win_s ? m1_rw_address   : m0_rw_address;
                    wdata_d    = win_s ? m1_write_data   : m0_write_data;
                    strb_d     = win_s ? m1_write_strobe : m0_write_strobe;
                    rd_req_d   = ~win_write_s;
                    wr_req_d   = win_write_s;
                    wd_cnt_d   = '0;
                    state_d    = BUSY;
`ifdef ARBITER_ROUND_ROBIN_EN
                    last_grant_d = win_s;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (rd_done_s || wr_done_s) begin
                    state_d = IDLE;
                end else if (WD_EN && (wd_cnt_q == WD_LIMIT)) begin
                    state_d = TIMEOUT;
                end else if (WD_EN) begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end else begin
                    wd_cnt_d = wd_cnt_q;
                end
            end
            TIMEOUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and command registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            is_write_q <= 1'b0;
            wd_cnt_q   <= '0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            strb_q     <= 4'd0;
            rd_req_q   <= 1'b0;
            wr_req_q   <= 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            is_write_q <= is_write_d;
            wd_cnt_q   <= wd_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            rd_req_q   <= rd_req_d;
            wr_req_q   <= wr_req_d;
`ifdef ARBITER_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign s_rw_address    = addr_q;
    assign s_write_data    = wdata_q;
    assign s_write_strobe  = strb_q;
    assign s_read_request  = rd_req_q;
    assign s_write_request = wr_req_q;

    // Responses are steered to the granted manager; read data passes through combinationally.
    assign m0_read_response  = rd_cpl_s & ~grant_q;
    assign m1_read_response  = rd_cpl_s &  grant_q;
    assign m0_write_response = wr_cpl_s & ~grant_q;
    assign m1_write_response = wr_cpl_s &  grant_q;
    assign m0_read_data      = (rd_done_s && !grant_q) ? s_read_data : 32'd0;
    assign m1_read_data      = (rd_done_s &&  grant_q) ? s_read_data : 32'd0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter (watchdog set to 4 cycles).
module tb_memory_arbiter;

    logic        clock;
    logic        reset;
    logic [31:0] m0_rw_address, m1_rw_address;
    logic [31:0] m0_write_data, m1_write_data;
    logic [3:0]  m0_write_strobe, m1_write_strobe;
    logic        m0_read_request, m1_read_request;
    logic        m0_write_request, m1_write_request;
    logic [31:0] m0_read_data, m1_read_data;
    logic        m0_read_response, m1_read_response;
    logic        m0_write_response, m1_write_response;
    logic [31:0] s_rw_address, s_write_data;
    logic [3:0]  s_write_strobe;
    logic        s_read_request, s_write_request;
    logic [31:0] s_read_data;
    logic        s_read_response, s_write_response;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr [3];
    logic        exp_m1   [3];
    int          drop0_at, drop1_at;

    memory_arbiter #(.WATCHDOG_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .m0_rw_address(m0_rw_address), .m1_rw_address(m1_rw_address),
        .m0_write_data(m0_write_data), .m1_write_data(m1_write_data),
        .m0_write_strobe(m0_write_strobe), .m1_write_strobe(m1_write_strobe),
        .m0_read_request(m0_read_request), .m1_read_request(m1_read_request),
        .m0_write_request(m0_write_request), .m1_write_request(m1_write_request),
        .m0_read_data(m0_read_data), .m1_read_data(m1_read_data),
        .m0_read_response(m0_read_response), .m1_read_response(m1_read_response),
        .m0_write_response(m0_write_response), .m1_write_response(m1_write_response),
        .s_rw_address(s_rw_address), .s_write_data(s_write_data),
        .s_write_strobe(s_write_strobe),
        .s_read_request(s_read_request), .s_write_request(s_write_request),
        .s_read_data(s_read_data),
        .s_read_response(s_read_response), .s_write_response(s_write_response)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        m0_rw_address = 32'd0; m1_rw_address = 32'd0;
        m0_write_data = 32'd0; m1_write_data = 32'd0;
        m0_write_strobe = 4'd0; m1_write_strobe = 4'd0;
        m0_read_request = 1'b0; m1_read_request = 1'b0;
        m0_write_request = 1'b0; m1_write_request = 1'b0;
        s_read_data = 32'd0; s_read_response = 1'b0; s_write_response = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rreq"}, {31'd0, s_read_request}, 32'd0);
        chk({tag, "_wreq"}, {31'd0, s_write_request}, 32'd0);
        chk({tag, "_addr"}, s_rw_address, 32'd0);
        chk({tag, "_wdat"}, s_write_data, 32'd0);
        chk({tag, "_strb"}, {28'd0, s_write_strobe}, 32'd0);
        chk({tag, "_resp"}, {28'd0, m0_read_response, m1_read_response,
                             m0_write_response, m1_write_response}, 32'd0);
        chk({tag, "_rdat"}, m0_read_data | m1_read_data, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        #2;
        chk_quiet("reset");
        tick(); tick();
        reset = 1'b1;

        // Simultaneous writes: m0 first, m1 two cycles later.
        tick();
        m0_write_request = 1'b1; m0_rw_address = 32'h100; m0_write_data = 32'hAAAA0001; m0_write_strobe = 4'hF;
        m1_write_request = 1'b1; m1_rw_address = 32'h200; m1_write_data = 32'hBBBB0002; m1_write_strobe = 4'h3;
        tick();
        chk("dual_wreq0", {31'd0, s_write_request}, 32'd1);
        chk("dual_addr0", s_rw_address, 32'h100);
        chk("dual_strb0", {28'd0, s_write_strobe}, 32'hF);
        s_write_response = 1'b1;
        #1;
        chk("dual_m0wr", {31'd0, m0_write_response}, 32'd1);
        chk("dual_m1wr0", {31'd0, m1_write_response}, 32'd0);
        tick();
        m0_write_request = 1'b0; s_write_response = 1'b0;
        chk("dual_gap", {31'd0, s_write_request}, 32'd0);
        tick();
        chk("dual_wreq1", {31'd0, s_write_request}, 32'd1);
        chk("dual_addr1", s_rw_address, 32'h200);
        chk("dual_strb1", {28'd0, s_write_strobe}, 32'h3);
        chk("dual_wdat1", s_write_data, 32'hBBBB0002);
        s_write_response = 1'b1;
        #1;
        chk("dual_m1wr", {31'd0, m1_write_response}, 32'd1);
        chk("dual_m0wr0", {31'd0, m0_write_response}, 32'd0);
        tick();
        clear_inputs();

        // m0 read, subordinate answers one cycle after the request.
        tick();
        m0_read_request = 1'b1; m0_rw_address = 32'h10;
        tick();
        chk("rd_sreq", {31'd0, s_read_request}, 32'd1);
        chk("rd_swreq", {31'd0, s_write_request}, 32'd0);
        chk("rd_addr", s_rw_address, 32'h10);
        chk("rd_early", {31'd0, m0_read_response}, 32'd0);
        tick();
        s_read_response = 1'b1; s_read_data = 32'hDEADBEEF;
        #1;
        chk("rd_sreq_low", {31'd0, s_read_request}, 32'd0);
        chk("rd_resp", {31'd0, m0_read_response}, 32'd1);
        chk("rd_data", m0_read_data, 32'hDEADBEEF);
        chk("rd_m1", {30'd0, m1_read_response, m1_write_response}, 32'd0);
        chk("rd_m1data", m1_read_data, 32'd0);
        chk("rd_m0wr", {31'd0, m0_write_response}, 32'd0);
        tick();
        m0_read_request = 1'b0;
        #1;
        chk("rd_late_resp", {31'd0, m0_read_response}, 32'd0);
        chk("rd_late_data", m0_read_data, 32'd0);
        clear_inputs();

        // Combined read+write is a write; a wrong-type response is ignored.
        tick();
        m0_read_request = 1'b1; m0_write_request = 1'b1;
        m0_rw_address = 32'h40; m0_write_data = 32'h12345678; m0_write_strobe = 4'hF;
        tick();
        chk("rw_wreq", {31'd0, s_write_request}, 32'd1);
        chk("rw_rreq", {31'd0, s_read_request}, 32'd0);
        chk("rw_addr", s_rw_address, 32'h40);
        chk("rw_wdat", s_write_data, 32'h12345678);
        tick();
        s_read_response = 1'b1;
        #1;
        chk("rw_wrongtype", {30'd0, m0_read_response, m0_write_response}, 32'd0);
        tick();
        s_read_response = 1'b0; s_write_response = 1'b1;
        #1;
        chk("rw_wresp", {31'd0, m0_write_response}, 32'd1);
        chk("rw_rresp", {31'd0, m0_read_response}, 32'd0);
        tick();
        clear_inputs();
        #1;
        chk("rw_pulse", {31'd0, m0_write_response}, 32'd0);

        // Contention with m0 re-requesting.
`ifdef ARBITER_ROUND_ROBIN_EN
        exp_addr[0] = 32'h400; exp_addr[1] = 32'h300; exp_addr[2] = 32'h300;
        exp_m1[0] = 1'b1; exp_m1[1] = 1'b0; exp_m1[2] = 1'b0;
        drop1_at = 0; drop0_at = 2;
`else
        exp_addr[0] = 32'h300; exp_addr[1] = 32'h300; exp_addr[2] = 32'h400;
        exp_m1[0] = 1'b0; exp_m1[1] = 1'b0; exp_m1[2] = 1'b1;
        drop0_at = 1; drop1_at = 2;
`endif
        tick();
        m0_read_request = 1'b1; m0_rw_address = 32'h300;
        m1_read_request = 1'b1; m1_rw_address = 32'h400;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("arb_addr", s_rw_address, exp_addr[i]);
            chk("arb_rreq", {31'd0, s_read_request}, 32'd1);
            s_read_response = 1'b1; s_read_data = 32'hA0 + 32'(i);
            #1;
            chk("arb_resp", {30'd0, m1_read_response, m0_read_response},
                exp_m1[i] ? 32'd2 : 32'd1);
            chk("arb_data", exp_m1[i] ? m1_read_data : m0_read_data, 32'hA0 + 32'(i));
            tick();
            s_read_response = 1'b0;
            if (i == drop0_at) m0_read_request = 1'b0;
            if (i == drop1_at) m1_read_request = 1'b0;
        end
        clear_inputs();

        // Watchdog: m1 read never answered.
        tick();
        m1_read_request = 1'b1; m1_rw_address = 32'h500;
        tick();
        chk("wd_sreq", {31'd0, s_read_request}, 32'd1);
        s_read_data = 32'hFFFFFFFF;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("wd_wait", {31'd0, m1_read_response}, 32'd0);
        end
        tick();
        chk("wd_resp", {31'd0, m1_read_response}, 32'd1);
        chk("wd_data", m1_read_data, 32'd0);
        chk("wd_m0", {31'd0, m0_read_response}, 32'd0);
        tick();
        m1_read_request = 1'b0; s_read_response = 1'b1;
        #1;
        chk("wd_once", {31'd0, m1_read_response}, 32'd0);
        chk("wd_late", m1_read_data, 32'd0);
        tick();
        s_read_response = 1'b0;
        m0_read_request = 1'b1; m0_rw_address = 32'h600;
        tick();
        chk("wd_next_addr", s_rw_address, 32'h600);
        chk("wd_next_rreq", {31'd0, s_read_request}, 32'd1);
        s_read_response = 1'b1; s_read_data = 32'h0BADF00D;
        #1;
        chk("wd_next_resp", {31'd0, m0_read_response}, 32'd1);
        chk("wd_next_data", m0_read_data, 32'h0BADF00D);
        tick();
        clear_inputs();

        // Reset during BUSY abandons the transaction.
        tick();
        m1_write_request = 1'b1; m1_rw_address = 32'h700; m1_write_data = 32'hCAFE0000; m1_write_strobe = 4'hC;
        tick();
        chk("rst_wreq", {31'd0, s_write_request}, 32'd1);
        tick();
        reset = 1'b0; s_write_response = 1'b1;
        #1;
        chk_quiet("rst_busy");
        tick();
        chk_quiet("rst_hold");
        s_write_response = 1'b0; m1_rw_address = 32'h800;
        reset = 1'b1;
        tick();
        chk("rst_next_wreq", {31'd0, s_write_request}, 32'd1);
        chk("rst_next_addr", s_rw_address, 32'h800);
        s_write_response = 1'b1;
        #1;
        chk("rst_next_resp", {31'd0, m1_write_response}, 32'd1);
        tick();
        clear_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
